zom_wave_scheduler: RTL and testbench

Sequences zombie attack waves for the game by driving a bank of NUM_ZOM zombie motion slots.
- Spawns zombies at fixed frame intervals into the lowest free slot, with the lane chosen by an LFSR.
- Counts kills and advances waves.
- Declares win after the last wave, or lose when any live zombie reaches the house.
- Sits between the game top-level and the per-zombie motion instances; clocked by the frame clock.

---
 rtl/zom_wave_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_zom_wave_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zom_wave_scheduler.sv
// Zombie wave scheduler: spawns zombies into free motion slots on a frame timer,
// counts kills, advances waves and reports win/lose for the game top-level.
module zom_wave_scheduler #(
  parameter int NUM_ZOM        = 4,
  parameter int NUM_LANES      = 5,
  parameter int LANE_Y0        = 80,
  parameter int LANE_PITCH     = 96,
  parameter int START_X        = 639,
  parameter int SPAWN_INTERVAL = 180,
  parameter int WAVE_PAUSE     = 600,
  parameter int WAVES          = 3,
  parameter int WAVE_SIZE      = 6,
  parameter int WAVE_GROWTH    = 2
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [NUM_ZOM-1:0]    zom_end,
  input  logic [NUM_ZOM-1:0]    zom_kill,
  output logic [NUM_ZOM-1:0]    zom_live,
  output logic [10*NUM_ZOM-1:0] zom_startX,
  output logic [10*NUM_ZOM-1:0] zom_startY,
  output logic                  spawn_pulse,
  output logic [3:0]            wave_num,
  output logic [7:0]            zombies_left,
  output logic                  game_over,
  output logic                  game_win,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN_WAIT, S_SPAWN, S_WAVE_PAUSE, S_WIN, S_LOSE
  } state_t;

  state_t               state_q, state_n;
  logic [11:0]          timer_q, timer_n;
  logic [3:0]           wave_q, wave_n;
  logic [7:0]           spawned_q, spawned_n;
  logic [7:0]           killed_q, killed_n;
  logic [7:0]           left_q, left_n;
  logic [7:0]           lfsr_q, lfsr_n;
  logic [NUM_ZOM-1:0]   live_q, live_n;
  logic [10*NUM_ZOM-1:0] sx_q, sx_n, sy_q, sy_n;

  logic [NUM_ZOM-1:0]   valid_kill, free_oh;
  logic [7:0]           kill_cnt, wave_size;
  logic                 lose_hit, free_any;
  logic [3:0]           lane_raw;
  logic [2:0]           lane;
  logic [9:0]           spawn_y;

  function automatic logic [7:0] size_of(input logic [3:0] w);
    return 8'(WAVE_SIZE) + 8'(w) * 8'(WAVE_GROWTH);
  endfunction

  assign wave_size  = size_of(wave_q);
  assign valid_kill = zom_kill & live_q;
  assign lose_hit   = |(zom_end & live_q);
  // Lowest clear bit of the live mask, as a one-hot.
  assign free_oh    = ~live_q & (live_q + NUM_ZOM'(1));
  assign free_any   = |free_oh;

  assign lane_raw = {1'b0, lfsr_q[2:0]};
  assign lane     = (lane_raw >= 4'(NUM_LANES)) ? 3'(lane_raw - 4'(NUM_LANES)) : lane_raw[2:0];
  assign spawn_y  = 10'(LANE_Y0) + 10'(lane) * 10'(LANE_PITCH);

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < NUM_ZOM; i++) kill_cnt = kill_cnt + 8'(valid_kill[i]);
  end

  always_comb begin
    state_n   = state_q;
    timer_n   = timer_q;
    wave_n    = wave_q;
    spawned_n = spawned_q;
    killed_n  = killed_q;
    left_n    = left_q;
    lfsr_n    = lfsr_q;
    live_n    = live_q;
    sx_n      = sx_q;
    sy_n      = sy_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_n   = S_SPAWN_WAIT;
          timer_n   = '0;
          wave_n    = '0;
          spawned_n = '0;
          killed_n  = '0;
          left_n    = size_of(4'd0);
        end
      end
      default: begin
        live_n   = live_q & ~valid_kill;
        killed_n = killed_q + kill_cnt;
        left_n   = wave_size - killed_n;
        if (lose_hit) begin
          // Reaching the house wins over any kill, spawn or wave end this cycle.
          state_n  = S_LOSE;
          live_n   = '0;
          killed_n = killed_q;
          left_n   = left_q;
        end else if (state_q != S_WAVE_PAUSE && killed_n == wave_size) begin
          timer_n = '0;
          if (wave_q == 4'(WAVES - 1)) begin
            state_n = S_WIN;
            live_n  = '0;
          end else begin
            state_n = S_WAVE_PAUSE;
          end
        end else if (state_q == S_SPAWN_WAIT) begin
          if (timer_q == 12'(SPAWN_INTERVAL - 1)) begin
            if (spawned_q < wave_size && free_any) state_n = S_SPAWN;
          end else begin
            timer_n = timer_q + 12'd1;
          end
        end else if (state_q == S_SPAWN) begin
          live_n = live_n | free_oh;
          for (int i = 0; i < NUM_ZOM; i++) begin
            if (free_oh[i]) begin
              sx_n[10*i +: 10] = 10'(START_X);
              sy_n[10*i +: 10] = spawn_y;
            end
          end
          spawned_n = spawned_q + 8'd1;
          lfsr_n    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          timer_n   = '0;
          state_n   = S_SPAWN_WAIT;
        end else begin
          if (timer_q == 12'(WAVE_PAUSE - 1)) begin
            wave_n    = wave_q + 4'd1;
            spawned_n = '0;
            killed_n  = '0;
            timer_n   = '0;
            left_n    = size_of(wave_q + 4'd1);
            state_n   = S_SPAWN_WAIT;
          end else begin
            timer_n = timer_q + 12'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      wave_q    <= '0;
      spawned_q <= '0;
      killed_q  <= '0;
      left_q    <= '0;
      lfsr_q    <= 8'hA5;
      live_q    <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      wave_q    <= wave_n;
      spawned_q <= spawned_n;
      killed_q  <= killed_n;
      left_q    <= left_n;
      lfsr_q    <= lfsr_n;
      live_q    <= live_n;
      sx_q      <= sx_n;
      sy_q      <= sy_n;
    end
  end

  assign zom_live     = live_q;
  assign zom_startX   = sx_q;
  assign zom_startY   = sy_q;
  assign spawn_pulse  = (state_q == S_SPAWN);
  assign wave_num     = wave_q;
  assign zombies_left = left_q;
  assign game_over    = (state_q == S_LOSE);
  assign game_win     = (state_q == S_WIN);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_zom_wave_scheduler.sv
// Bench for zom_wave_scheduler: directed scenarios with literal expectations plus
// randomized play checked every cycle against a behavioural game model.
module tb_zom_wave_scheduler;

  localparam int NZ = 2, NL = 5, Y0 = 80, PITCH = 96, X0 = 639;
  localparam int SI = 4, WP = 3, NW = 2, WS0 = 2, WG = 1;
  localparam int M_IDLE = 0, M_WAIT = 1, M_SPAWN = 2, M_PAUSE = 3, M_WIN = 4, M_LOSE = 5;

  logic            frame_clk = 1'b0;
  logic            Reset = 1'b1;
  logic            start = 1'b0;
  logic [NZ-1:0]   zom_end = '0;
  logic [NZ-1:0]   zom_kill = '0;
  logic [NZ-1:0]   zom_live;
  logic [10*NZ-1:0] zom_startX, zom_startY;
  logic            spawn_pulse, game_over, game_win;
  logic [3:0]      wave_num;
  logic [7:0]      zombies_left;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;
  logic [9:0] exp_q[$];

  // clock / reset
  always #5 frame_clk = ~frame_clk;

  zom_wave_scheduler #(
    .NUM_ZOM(NZ), .NUM_LANES(NL), .LANE_Y0(Y0), .LANE_PITCH(PITCH), .START_X(X0),
    .SPAWN_INTERVAL(SI), .WAVE_PAUSE(WP), .WAVES(NW), .WAVE_SIZE(WS0), .WAVE_GROWTH(WG)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .zom_end(zom_end),
    .zom_kill(zom_kill), .zom_live(zom_live), .zom_startX(zom_startX),
    .zom_startY(zom_startY), .spawn_pulse(spawn_pulse), .wave_num(wave_num),
    .zombies_left(zombies_left), .game_over(game_over), .game_win(game_win),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the game
  int m_mode = M_IDLE, m_timer = 0, m_wave = 0, m_spawned = 0, m_killed = 0, m_left = 0;
  int m_lfsr = 'hA5;
  bit m_live[NZ];
  int m_x[NZ];
  int m_y[NZ];

  function automatic int ws(input int w);
    return (WS0 + w * WG) & 255;
  endfunction

  task automatic model_step();
    int kills, slot, l;
    bit hit;
    if (Reset) begin
      m_mode = M_IDLE; m_timer = 0; m_wave = 0; m_spawned = 0; m_killed = 0; m_left = 0;
      m_lfsr = 'hA5;
      for (int i = 0; i < NZ; i++) begin m_live[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      return;
    end
    if (m_mode == M_IDLE || m_mode == M_WIN || m_mode == M_LOSE) begin
      if (start) begin
        m_mode = M_WAIT; m_timer = 0; m_wave = 0; m_spawned = 0; m_killed = 0; m_left = ws(0);
      end
      return;
    end
    kills = 0; hit = 0; slot = -1;
    for (int i = 0; i < NZ; i++) begin
      if (m_live[i] && zom_kill[i]) kills++;
      if (m_live[i] && zom_end[i]) hit = 1;
      if (!m_live[i] && slot < 0) slot = i;
    end
    if (hit) begin
      m_mode = M_LOSE;
      for (int i = 0; i < NZ; i++) m_live[i] = 0;
      return;
    end
    for (int i = 0; i < NZ; i++) if (zom_kill[i]) m_live[i] = 0;
    m_killed += kills;
    m_left = (ws(m_wave) - m_killed) & 255;
    if (m_mode != M_PAUSE && m_killed == ws(m_wave)) begin
      m_timer = 0;
      if (m_wave == NW - 1) begin
        m_mode = M_WIN;
        for (int i = 0; i < NZ; i++) m_live[i] = 0;
      end else m_mode = M_PAUSE;
    end else if (m_mode == M_WAIT) begin
      if (m_timer == SI - 1) begin
        if (m_spawned < ws(m_wave) && slot >= 0) m_mode = M_SPAWN;
      end else m_timer++;
    end else if (m_mode == M_SPAWN) begin
      l = m_lfsr & 7;
      if (l >= NL) l -= NL;
      if (slot >= 0) begin
        m_live[slot] = 1;
        m_x[slot] = X0;
        m_y[slot] = (Y0 + l * PITCH) % 1024;
        exp_q.push_back(10'(m_y[slot]));
      end
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
      m_spawned++; m_timer = 0; m_mode = M_WAIT;
    end else begin
      if (m_timer == WP - 1) begin
        m_wave++; m_spawned = 0; m_killed = 0; m_timer = 0; m_left = ws(m_wave); m_mode = M_WAIT;
      end else m_timer++;
    end
  endtask

  always @(posedge frame_clk) model_step();

  // scoreboard: per-cycle compare plus spawn-position queue
  logic [NZ-1:0] prev_live = '0;
  always @(negedge frame_clk) begin
    logic [NZ-1:0]    e_live, newly;
    logic [10*NZ-1:0] e_x, e_y;
    logic [9:0]       y_exp, y_act;
    if (chk_en) begin
      for (int i = 0; i < NZ; i++) begin
        e_live[i] = m_live[i];
        e_x[10*i +: 10] = 10'(m_x[i]);
        e_y[10*i +: 10] = 10'(m_y[i]);
      end
      check("zom_live", zom_live, e_live);
      check("startX", zom_startX, e_x);
      check("startY", zom_startY, e_y);
      check("spawn_pulse", spawn_pulse, m_mode == M_SPAWN);
      check("wave_num", wave_num, 4'(m_wave));
      check("zombies_left", zombies_left, 8'(m_left));
      check("game_over", game_over, m_mode == M_LOSE);
      check("game_win", game_win, m_mode == M_WIN);
      if (exp_q.size() > 0) begin
        y_exp = exp_q.pop_front();
        newly = zom_live & ~prev_live;
        y_act = '0;
        for (int i = NZ - 1; i >= 0; i--) if (newly[i]) y_act = zom_startY[10*i +: 10];
        check("spawn_y_queue", y_act, y_exp);
      end
    end
    prev_live = zom_live;
  end

  // driver tasks
  task automatic step();
    @(negedge frame_clk);
  endtask

  task automatic wait_spawn(input int limit, output int waited);
    waited = 0;
    while (spawn_pulse !== 1'b1 && waited < limit) begin
      step();
      waited++;
    end
    check("spawn_seen", spawn_pulse, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int w;
    step();
    chk_en = 1;
    step();
    Reset = 1'b0;
    check("rst_live", zom_live, 2'b00);
    check("rst_left", zombies_left, 8'd0);
    check("rst_flags", {game_over, game_win, spawn_pulse}, 3'b000);

    // first two spawns: lane 0 from seed A5, then lane 2 from 4A
    pulse_start();
    wait_spawn(20, w);
    check("first_spawn_delay", w, 4);
    step();
    check("spawn0_live", zom_live, 2'b01);
    check("spawn0_x", zom_startX[9:0], 10'd639);
    check("spawn0_y", zom_startY[9:0], 10'd80);
    wait_spawn(20, w);
    check("second_spawn_delay", w, 4);
    step();
    check("spawn1_live", zom_live, 2'b11);
    check("spawn1_y", zom_startY[19:10], 10'd272);

    // double kill ends wave 0, then a 3-cycle pause
    zom_kill = 2'b11;
    step();
    zom_kill = 2'b00;
    check("w0_done_left", zombies_left, 8'd0);
    step();
    step();
    check("pause_wave", wave_num, 4'd0);
    step();
    check("w1_wave", wave_num, 4'd1);
    check("w1_left", zombies_left, 8'd3);

    // wave 1: both slots full, timer must hold
    wait_spawn(20, w);
    step();
    wait_spawn(20, w);
    step();
    check("w1_full", zom_live, 2'b11);
    for (int i = 0; i < 8; i++) begin
      step();
      check("hold_no_spawn", spawn_pulse, 1'b0);
    end
    zom_kill = 2'b01;
    step();
    zom_kill = 2'b00;
    check("slot0_freed", zom_live, 2'b10);
    step();
    check("respawn_now", spawn_pulse, 1'b1);
    step();
    check("respawn_slot0", zom_live, 2'b11);

    // last two kills of the final wave -> win
    zom_kill = 2'b11;
    step();
    zom_kill = 2'b00;
    check("win_flag", game_win, 1'b1);
    check("win_live", zom_live, 2'b00);
    step();
    check("win_hold", game_win, 1'b1);
    pulse_start();
    check("restart_wave", wave_num, 4'd0);
    check("restart_left", zombies_left, 8'd2);
    check("restart_win", game_win, 1'b0);

    // end on a dead slot is ignored; end+kill on a live slot loses
    wait_spawn(20, w);
    step();
    zom_end = 2'b10;
    step();
    zom_end = 2'b00;
    check("dead_end_ignored", game_over, 1'b0);
    check("dead_end_live", zom_live, 2'b01);
    wait_spawn(20, w);
    step();
    zom_end = 2'b10;
    zom_kill = 2'b10;
    step();
    zom_end = 2'b00;
    zom_kill = 2'b00;
    check("lose_flag", game_over, 1'b1);
    check("lose_live", zom_live, 2'b00);

    // reset mid-wait with a live zombie
    pulse_start();
    wait_spawn(20, w);
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_live", zom_live, 2'b00);
    check("midrst_xy", {zom_startX, zom_startY}, 40'd0);
    check("midrst_misc", {wave_num, zombies_left, spawn_pulse, game_over, game_win}, 15'd0);

    // kills on empty slots do not count
    pulse_start();
    check("pre_dead_kill_left", zombies_left, 8'd2);
    zom_kill = 2'b11;
    step();
    zom_kill = 2'b00;
    check("dead_kill_left", zombies_left, 8'd2);

    // randomized play against the model
    for (int c = 0; c < 4000; c++) begin
      Reset    = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 29) == 0);
      zom_kill = ($urandom_range(0, 5) == 0) ? NZ'($urandom_range(1, 3)) : '0;
      zom_end  = ($urandom_range(0, 149) == 0) ? NZ'($urandom_range(1, 3)) : '0;
      step();
    end
    Reset = 1'b0;
    start = 1'b0;
    zom_kill = '0;
    zom_end = '0;
    step();
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
